// File: rtl/pipelined_adder.sv
// Segmented add/subtract: one SEG_W-bit carry-chained slice per stage, NSEG = ceil(WIDTH/SEG_W) stages.
// Latency: an op accepted at edge E is presented after edge E+NSEG-1; throughput 1 op/cycle.
// Backpressure: stages advance when empty or downstream advances; in_ready falls only with all stages full and out_ready low.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

    // Per-stage state: operands still to be summed, partial sum so far, carry out of the slice.
    logic [NSEG-1:0]  st_v;
    logic [NSEG-1:0]  st_c;
    logic [WIDTH-1:0] st_a [NSEG];
    logic [WIDTH-1:0] st_b [NSEG];
    logic [WIDTH-1:0] st_s [NSEG];
    logic             ovf_q;

    // Next-state values each stage would capture when it advances.
    logic [NSEG-1:0]  v_nxt;
    logic [NSEG-1:0]  c_nxt;
    logic [NSEG-1:0]  adv;
    logic [WIDTH-1:0] a_nxt [NSEG];
    logic [WIDTH-1:0] b_nxt [NSEG];
    logic [WIDTH-1:0] s_nxt [NSEG];
    logic             ovf_nxt;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * SEG_W;
        localparam int HI = (LO + SEG_W < WIDTH) ? LO + SEG_W - 1 : WIDTH - 1;
        localparam int W  = HI - LO + 1;
        localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - W)) << LO;

        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [W:0]       seg;

        if (k == 0) begin : g_in
            // Subtract is folded in here (invert B, force carry-in) so later stages never see sub/ci.
            assign a_src = a;
            assign b_src = sub ? ~b : b;
            assign s_src = '0;
            assign c_src = sub | ci;
            assign v_src = in_valid & adv[0];
        end else begin : g_chain
            assign a_src = st_a[k-1];
            assign b_src = st_b[k-1];
            assign s_src = st_s[k-1];
            assign c_src = st_c[k-1];
            assign v_src = st_v[k-1];
        end

        assign seg      = {1'b0, a_src[HI:LO]} + {1'b0, b_src[HI:LO]} + {{W{1'b0}}, c_src};
        assign a_nxt[k] = a_src;
        assign b_nxt[k] = b_src;
        assign s_nxt[k] = (s_src & ~MASK) | (WIDTH'(seg[W-1:0]) << LO);
        assign c_nxt[k] = seg[W];
        assign v_nxt[k] = v_src;

        // A stage can move when it, or any stage between it and the output, has a hole, or the sink takes a result.
        assign adv[k] = out_ready | ~(&st_v[NSEG-1:k]);

        if (k == NSEG - 1) begin : g_ovf
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
            assign ovf_nxt = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ s_nxt[k][WIDTH-1] ^ seg[W];
        end
    end

    // Pipeline registers: valid bits follow the flow rule; data is captured only for real ops so bubbles hold old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v  <= '0;
            st_c  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (adv[k]) begin
                    st_v[k] <= v_nxt[k];
                    if (v_nxt[k]) begin
                        st_a[k] <= a_nxt[k];
                        st_b[k] <= b_nxt[k];
                        st_s[k] <= s_nxt[k];
                        st_c[k] <= c_nxt[k];
                    end
                end
            end
            if (adv[NSEG-1] && v_nxt[NSEG-1]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = st_v[NSEG-1];
    assign sum       = st_s[NSEG-1];
    assign co        = st_c[NSEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (32/8, 13/4, 1/8) share one random stimulus stream.
// Each instance has a queue-based arithmetic model; outputs checked every negedge.
// Literal vectors pin the model; random out_ready exercises stall and flow rules.
module tb_pipelined_adder;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        ci        = 1'b0;
    logic        sub       = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;

    logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
    logic [31:0] s0;
    logic [12:0] s1;
    logic [0:0]  s2;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .SEG_W(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .sum(s0), .co(co0), .ovf(of0));

    pipelined_adder #(.WIDTH(13), .SEG_W(4)) u_w13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a[12:0]), .b(b[12:0]), .ci(ci), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .co(co1), .ovf(of1));

    pipelined_adder #(.WIDTH(1), .SEG_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a[0:0]), .b(b[0:0]), .ci(ci), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .co(co2), .ovf(of2));

    logic        ir [3];
    logic        ov [3];
    logic        cov [3];
    logic        ofv [3];
    logic [31:0] sv [3];
    assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = ir2;
    assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
    assign cov[0] = co0; assign cov[1] = co1; assign cov[2] = co2;
    assign ofv[0] = of0; assign ofv[1] = of1; assign ofv[2] = of2;
    assign sv[0] = s0;
    assign sv[1] = {19'd0, s1};
    assign sv[2] = {31'd0, s2};

    int wid  [3] = '{32, 13, 1};
    int nseg [3] = '{4, 4, 1};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit free_flow = 1'b0;

    logic [33:0] expq [3][$];
    int          tq   [3][$];
    bit          stall_prev [3];
    logic [33:0] held [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic at width w; overflow from operand/result signs.
    function automatic logic [33:0] model(input logic [31:0] a_i, input logic [31:0] b_i,
                                          input logic ci_i, input logic sub_i, input int w);
        logic [63:0] mask, ae, be, tot;
        logic [31:0] s;
        logic        co_r, ov_r;
        mask = (64'd1 << w) - 64'd1;
        ae   = {32'd0, a_i} & mask;
        be   = (sub_i ? ~{32'd0, b_i} : {32'd0, b_i}) & mask;
        tot  = ae + be + (sub_i ? 64'd1 : {63'd0, ci_i});
        s    = 32'(tot & mask);
        co_r = tot[w];
        ov_r = (ae[w-1] == be[w-1]) && (s[w-1] != ae[w-1]);
        return {ov_r, co_r, s};
    endfunction

    // Compare process: flow rule, stall stability, result order/value and latency per instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                expq[i].delete();
                tq[i].delete();
                stall_prev[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready[%0d]", i), 64'(ir[i]),
                      64'(!(expq[i].size() == nseg[i] && !out_ready)));
                if (stall_prev[i]) begin
                    check($sformatf("stall_valid[%0d]", i), 64'(ov[i]), 64'd1);
                    check($sformatf("stall_hold[%0d]", i), 64'({ofv[i], cov[i], sv[i]}), 64'(held[i]));
                end
                if (ov[i]) begin
                    check($sformatf("no_spurious[%0d]", i), 64'(expq[i].size() > 0), 64'd1);
                    if (expq[i].size() > 0) begin
                        check($sformatf("result[%0d]", i), 64'({ofv[i], cov[i], sv[i]}), 64'(expq[i][0]));
                        if (!stall_prev[i]) begin
                            if (free_flow)
                                check($sformatf("latency[%0d]", i), 64'(cyc - tq[i][0]), 64'(nseg[i]));
                            else
                                check($sformatf("latency_min[%0d]", i), 64'(cyc - tq[i][0] >= nseg[i]), 64'd1);
                        end
                        if (out_ready) begin
                            void'(expq[i].pop_front());
                            void'(tq[i].pop_front());
                        end
                    end
                end
                stall_prev[i] = ov[i] && !out_ready;
                held[i]       = {ofv[i], cov[i], sv[i]};
                if (in_valid && ir[i]) begin
                    expq[i].push_back(model(a, b, ci, sub, wid[i]));
                    tq[i].push_back(cyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic rand_ops;
        a   = $urandom;
        b   = $urandom;
        ci  = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    // One op into an empty, free-flowing pipe; literal result and edge count checked on the 32-bit instance.
    task automatic directed(input string nm, input logic [31:0] a_i, input logic [31:0] b_i,
                            input logic ci_i, input logic sub_i,
                            input logic [31:0] e_sum, input logic e_co, input logic e_ovf);
        int n;
        drain();
        free_flow = 1'b1;
        a = a_i; b = b_i; ci = ci_i; sub = sub_i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov0 && n < 20) begin
            tick();
            n++;
        end
        // Accepted at edge E, presented after edge E+3.
        check({nm, "_edges"}, 64'(n), 64'd3);
        check({nm, "_sum"}, 64'(s0), 64'(e_sum));
        check({nm, "_co"}, 64'(co0), 64'(e_co));
        check({nm, "_ovf"}, 64'(of0), 64'(e_ovf));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
            check($sformatf("rst_out[%0d]", i), 64'({ofv[i], cov[i], sv[i]}), 64'd0);
        end
        a = 32'h1234_5678; b = 32'h9abc_def0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("idle_hold_sum", 64'(s0), 64'd0);
        check("idle_hold_valid", 64'(ov0), 64'd0);

        directed("carry_seg",  32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        directed("ripple",     32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0);
        directed("pos_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_borrow", 32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_pos",    32'h7,         32'h5, 1'b0, 1'b1, 32'h2,         1'b1, 1'b0);

        // 100 back-to-back random ops with the sink always ready.
        drain();
        free_flow = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Random sink stalls (about 30% low) and gappy source.
        free_flow = 1'b0;
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) >= 3);
            tick();
        end
        drain();
        for (int i = 0; i < 3; i++)
            check($sformatf("drained[%0d]", i), 64'(expq[i].size()), 64'd0);

        // Fill the pipe, then reset mid-cycle with ops in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("full_before_reset", 64'(ir0), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
        check("async_rst_sum", 64'(s0), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_ready", 64'({ir0, ir1, ir2}), 64'h7);
            check("post_rst_quiet", 64'({ov0, ov1, ov2}), 64'h0);
        end
        out_ready = 1'b1;
        directed("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
